// File: rtl/apb2lb_tmo.sv
`default_nettype none
// ============================================================================
// Module   : apb2lb_tmo
// Purpose  : APB4 (APB3-compatible) slave to local-bus bridge with a
//            programmable response timeout. One APB transfer at a time is
//            turned into a local-bus write strobe or read request. If the
//            local-bus slave stays silent too long, the transfer ends with
//            PSLVERR.
// Ports    : clk, rst                      - clock, synchronous active-high reset
//            psel/penable/pwrite/paddr/
//            pwdata/pstrb                  - APB requester side
//            prdata/pready/pslverr         - APB completion (all registered)
//            lb_waddr/lb_wdata/lb_wstrb/
//            lb_wen, lb_wready             - local-bus write channel
//            lb_raddr/lb_ren,
//            lb_rdata/lb_rvalid            - local-bus read channel
// Revision : 1.0 - initial release
// ============================================================================
module apb2lb_tmo #(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 32,
    parameter int                STRB_W    = DATA_W / 8,
    parameter bit                USE_PSTRB = 1'b1,
    parameter int                TIMEOUT   = 16,
    parameter logic [DATA_W-1:0] ERR_RDATA = DATA_W'(32'hBADC0DE0)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    input  logic [STRB_W-1:0] pstrb,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [ADDR_W-1:0] lb_waddr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic [STRB_W-1:0] lb_wstrb,
    output logic              lb_wen,
    input  logic              lb_wready,
    output logic [ADDR_W-1:0] lb_raddr,
    output logic              lb_ren,
    input  logic [DATA_W-1:0] lb_rdata,
    input  logic              lb_rvalid
);

    // The counter only has to reach TIMEOUT-1; with TIMEOUT=0 it is free-running
    // and never compared, so its width is irrelevant.
    localparam int                c_cnt_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit                c_tmo_en   = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_nx;
    logic                w_tmo;

    logic [DATA_W-1:0]   w_prdata_nx;
    logic                w_pready_nx;
    logic                w_pslverr_nx;
    logic [ADDR_W-1:0]   w_waddr_nx;
    logic [DATA_W-1:0]   w_wdata_nx;
    logic [STRB_W-1:0]   w_wstrb_nx;
    logic                w_wen_nx;
    logic [ADDR_W-1:0]   w_raddr_nx;
    logic                w_ren_nx;

    // Timeout fires in the cycle whose count is TIMEOUT-1, so the request is
    // outstanding for exactly TIMEOUT cycles before being abandoned.
    assign w_tmo = c_tmo_en && (r_cnt == c_tmo_last);

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_prdata_nx  = prdata;
        w_pready_nx  = 1'b0;
        w_pslverr_nx = pslverr;
        w_waddr_nx   = lb_waddr;
        w_wdata_nx   = lb_wdata;
        w_wstrb_nx   = lb_wstrb;
        w_wen_nx     = lb_wen;
        w_raddr_nx   = lb_raddr;
        w_ren_nx     = 1'b0;   // read request is a single-cycle pulse

        case (r_state)
            ST_IDLE: begin
                w_prdata_nx  = '0;
                w_pslverr_nx = 1'b0;
                w_wen_nx     = 1'b0;
                if (psel && !penable) begin
                    w_cnt_nx = '0;
                    if (pwrite) begin
                        w_waddr_nx = paddr;
                        w_wdata_nx = pwdata;
                        w_wstrb_nx = USE_PSTRB ? pstrb : {STRB_W{1'b1}};
                        w_wen_nx   = 1'b1;
                        w_state_nx = ST_WRITE;
                    end else begin
                        w_raddr_nx = paddr;
                        w_ren_nx   = 1'b1;
                        w_state_nx = ST_READ;
                    end
                end
            end

            ST_WRITE: begin
                if (lb_wready) begin
                    w_wen_nx     = 1'b0;
                    w_pslverr_nx = 1'b0;
                    w_pready_nx  = 1'b1;
                    w_state_nx   = ST_RESP;
                end else if (w_tmo) begin
                    w_wen_nx     = 1'b0;
                    w_pslverr_nx = 1'b1;
                    w_pready_nx  = 1'b1;
                    w_state_nx   = ST_RESP;
                end else begin
                    w_cnt_nx = r_cnt + c_cnt_w'(1);
                end
            end

            ST_READ: begin
                if (lb_rvalid) begin
                    w_prdata_nx  = lb_rdata;
                    w_pslverr_nx = 1'b0;
                    w_pready_nx  = 1'b1;
                    w_state_nx   = ST_RESP;
                end else if (w_tmo) begin
                    w_prdata_nx  = ERR_RDATA;
                    w_pslverr_nx = 1'b1;
                    w_pready_nx  = 1'b1;
                    w_state_nx   = ST_RESP;
                end else begin
                    w_cnt_nx = r_cnt + c_cnt_w'(1);
                end
            end

            ST_RESP: begin
                // pready lasts one cycle; read data and error are only
                // visible alongside it.
                w_prdata_nx  = '0;
                w_pslverr_nx = 1'b0;
                w_state_nx   = ST_IDLE;
            end

            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            prdata   <= '0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            lb_waddr <= '0;
            lb_wdata <= '0;
            lb_wstrb <= '0;
            lb_wen   <= 1'b0;
            lb_raddr <= '0;
            lb_ren   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            prdata   <= w_prdata_nx;
            pready   <= w_pready_nx;
            pslverr  <= w_pslverr_nx;
            lb_waddr <= w_waddr_nx;
            lb_wdata <= w_wdata_nx;
            lb_wstrb <= w_wstrb_nx;
            lb_wen   <= w_wen_nx;
            lb_raddr <= w_raddr_nx;
            lb_ren   <= w_ren_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb2lb_tmo.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb2lb_tmo
// Purpose  : Self-checking bench for apb2lb_tmo. Three bridges are built:
//            [0] defaults (APB4 strobes, TIMEOUT=16), [1] USE_PSTRB=0,
//            [2] TIMEOUT=0. Expected results come from a transaction-level
//            model: response delay d vs TIMEOUT decides completion or abort.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb2lb_tmo;

    localparam logic [31:0] ERR_RDATA = 32'hBADC0DE0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        psel      [3];
    logic        penable   [3];
    logic        pwrite    [3];
    logic [15:0] paddr     [3];
    logic [31:0] pwdata    [3];
    logic [3:0]  pstrb     [3];
    logic [31:0] prdata    [3];
    logic        pready    [3];
    logic        pslverr   [3];
    logic [15:0] lb_waddr  [3];
    logic [31:0] lb_wdata  [3];
    logic [3:0]  lb_wstrb  [3];
    logic        lb_wen    [3];
    logic        lb_wready [3];
    logic [15:0] lb_raddr  [3];
    logic        lb_ren    [3];
    logic [31:0] lb_rdata  [3];
    logic        lb_rvalid [3];

    int tmo_cfg   [3] = '{16, 16, 0};
    bit pstrb_cfg [3] = '{1'b1, 1'b0, 1'b1};

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb2lb_tmo #(
            .USE_PSTRB (g == 1 ? 1'b0 : 1'b1),
            .TIMEOUT   (g == 2 ? 0 : 16)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .psel      (psel[g]),
            .penable   (penable[g]),
            .pwrite    (pwrite[g]),
            .paddr     (paddr[g]),
            .pwdata    (pwdata[g]),
            .pstrb     (pstrb[g]),
            .prdata    (prdata[g]),
            .pready    (pready[g]),
            .pslverr   (pslverr[g]),
            .lb_waddr  (lb_waddr[g]),
            .lb_wdata  (lb_wdata[g]),
            .lb_wstrb  (lb_wstrb[g]),
            .lb_wen    (lb_wen[g]),
            .lb_wready (lb_wready[g]),
            .lb_raddr  (lb_raddr[g]),
            .lb_ren    (lb_ren[g]),
            .lb_rdata  (lb_rdata[g]),
            .lb_rvalid (lb_rvalid[g])
        );
    end

    // One APB transfer on bridge k; slave answers in cycle 'delay' counted from
    // the first request cycle (0 = same cycle as lb_wen/lb_ren).
    task automatic do_xfer(input int k, input bit wr, input logic [15:0] addr,
                           input logic [31:0] data, input logic [3:0] strb,
                           input int delay, input logic [31:0] rd, input string name);
        bit          tmo_exp;
        int          wait_exp;
        logic [3:0]  exp_strb;
        logic [31:0] exp_prdata;
        int          i;
        int          wen_n;
        int          ren_n;
        bit          done;
        bit          stable;
        bit          both;
        logic        got_err;
        logic [31:0] got_rd;

        tmo_exp    = (tmo_cfg[k] != 0) && (delay >= tmo_cfg[k]);
        wait_exp   = tmo_exp ? tmo_cfg[k] : delay + 1;
        exp_strb   = pstrb_cfg[k] ? strb : 4'hF;
        exp_prdata = wr ? 32'h0 : (tmo_exp ? ERR_RDATA : rd);

        psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr;
        paddr[k] = addr; pwdata[k] = data; pstrb[k] = strb;
        @(negedge clk);
        penable[k] = 1'b1;
        i = 0; done = 1'b0; stable = 1'b1; both = 1'b0; wen_n = 0; ren_n = 0;
        got_err = 1'b0; got_rd = '0;
        while (!done && i < 300) begin
            if (pready[k]) begin
                done    = 1'b1;
                got_err = pslverr[k];
                got_rd  = prdata[k];
            end else begin
                if (lb_wen[k] && lb_ren[k]) both = 1'b1;
                if (lb_wen[k]) begin
                    wen_n++;
                    if (lb_waddr[k] !== addr || lb_wdata[k] !== data || lb_wstrb[k] !== exp_strb)
                        stable = 1'b0;
                end
                if (lb_ren[k]) ren_n++;
                if (!wr && lb_raddr[k] !== addr) stable = 1'b0;
                lb_wready[k] = wr && (i == delay);
                lb_rvalid[k] = !wr && (i == delay);
                lb_rdata[k]  = (!wr && i == delay) ? rd : $urandom;
                i++;
                @(negedge clk);
            end
        end
        psel[k] = 1'b0; penable[k] = 1'b0; lb_wready[k] = 1'b0; lb_rvalid[k] = 1'b0;

        checks++;
        if (!done || i !== wait_exp) begin
            failures++;
            $display("FAIL %s pready_latency: got %0d (done=%0b) expected %0d", name, i, done, wait_exp);
        end
        checks++;
        if (got_err !== tmo_exp) begin
            failures++;
            $display("FAIL %s pslverr: got %0b expected %0b", name, got_err, tmo_exp);
        end
        checks++;
        if (got_rd !== exp_prdata) begin
            failures++;
            $display("FAIL %s prdata: got %h expected %h", name, got_rd, exp_prdata);
        end
        checks++;
        if (wr ? (wen_n !== wait_exp || ren_n !== 0) : (ren_n !== 1 || wen_n !== 0)) begin
            failures++;
            $display("FAIL %s request_cycles: got wen=%0d ren=%0d expected wen=%0d ren=%0d",
                     name, wen_n, ren_n, wr ? wait_exp : 0, wr ? 0 : 1);
        end
        checks++;
        if (!stable || both) begin
            failures++;
            $display("FAIL %s lb_stability: got stable=%0b overlap=%0b expected stable=1 overlap=0",
                     name, stable, both);
        end
        @(negedge clk);
        checks++;
        if (pready[k] !== 1'b0 || pslverr[k] !== 1'b0 || prdata[k] !== 32'h0 ||
            lb_wen[k] !== 1'b0 || lb_ren[k] !== 1'b0) begin
            failures++;
            $display("FAIL %s after_resp: got pready=%0b pslverr=%0b prdata=%h wen=%0b ren=%0b expected all 0",
                     name, pready[k], pslverr[k], prdata[k], lb_wen[k], lb_ren[k]);
        end
    endtask

    task automatic check_all_zero(input int k, input string name);
        checks++;
        if (prdata[k] !== 32'h0 || pready[k] !== 1'b0 || pslverr[k] !== 1'b0 ||
            lb_waddr[k] !== 16'h0 || lb_wdata[k] !== 32'h0 || lb_wstrb[k] !== 4'h0 ||
            lb_wen[k] !== 1'b0 || lb_raddr[k] !== 16'h0 || lb_ren[k] !== 1'b0) begin
            failures++;
            $display("FAIL %s outputs: got prdata=%h pready=%0b pslverr=%0b waddr=%h wdata=%h wstrb=%h wen=%0b raddr=%h ren=%0b expected all 0",
                     name, prdata[k], pready[k], pslverr[k], lb_waddr[k], lb_wdata[k],
                     lb_wstrb[k], lb_wen[k], lb_raddr[k], lb_ren[k]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) check_all_zero(k, "reset");
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_simple_write();
        do_xfer(0, 1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 0, 32'h0, "simple_write");
    endtask

    task automatic test_strobed_write();
        do_xfer(0, 1'b1, 16'h000C, 32'hCAFEBABE, 4'b0110, 0, 32'h0, "strobed_write");
        do_xfer(1, 1'b1, 16'h000C, 32'hCAFEBABE, 4'b0110, 0, 32'h0, "strobed_write_apb3");
    endtask

    task automatic test_write_wait();
        do_xfer(0, 1'b1, 16'h0010, 32'h0ACCE55, 4'hF, 5, 32'h0, "write_wait");
    endtask

    task automatic test_reads();
        do_xfer(0, 1'b0, 16'h0014, 32'h0, 4'h0, 1, 32'hC0DEBABE, "read_1wait");
        do_xfer(0, 1'b0, 16'h0008, 32'h0, 4'h0, 5, 32'hDEADBEEF, "read_5wait");
        do_xfer(0, 1'b0, 16'h0020, 32'h0, 4'h0, 0, 32'h12345678, "read_0wait");
    endtask

    task automatic test_timeout();
        bit quiet;
        do_xfer(0, 1'b1, 16'h0030, 32'h11112222, 4'hF, 1000, 32'h0, "write_timeout");
        do_xfer(0, 1'b0, 16'h0034, 32'h0, 4'h0, 1000, 32'h55AA55AA, "read_timeout");
        // late read data after the abort must not produce anything
        quiet = 1'b1;
        lb_rvalid[0] = 1'b1; lb_rdata[0] = 32'h5A5A5A5A;
        repeat (3) begin
            @(negedge clk);
            if (pready[0] !== 1'b0 || prdata[0] !== 32'h0 || pslverr[0] !== 1'b0) quiet = 1'b0;
        end
        lb_rvalid[0] = 1'b0;
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL late_rvalid: got response activity expected none");
        end
        do_xfer(0, 1'b0, 16'h0038, 32'h0, 4'h0, 2, 32'h600DF00D, "read_after_timeout");
        do_xfer(0, 1'b1, 16'h003C, 32'h0F0F0F0F, 4'hF, 15, 32'h0, "write_edge_15");
        do_xfer(0, 1'b0, 16'h0040, 32'h0, 4'h0, 16, 32'h77777777, "read_edge_16");
    endtask

    task automatic test_no_timeout();
        do_xfer(2, 1'b1, 16'h0044, 32'hFEEDFACE, 4'hF, 100, 32'h0, "stall_write_t0");
        do_xfer(2, 1'b0, 16'h0048, 32'h0, 4'h0, 100, 32'hABCDEF01, "stall_read_t0");
    endtask

    task automatic test_reset_mid_read();
        bit quiet;
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 16'h0050;
        @(negedge clk);
        penable[0] = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero(0, "reset_mid_read");
        rst = 1'b0; psel[0] = 1'b0; penable[0] = 1'b0;
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (pready[0] !== 1'b0 || lb_ren[0] !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL reset_mid_read_quiet: got pready/lb_ren activity expected none");
        end
        do_xfer(0, 1'b1, 16'h0054, 32'h13579BDF, 4'hF, 0, 32'h0, "write_after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int          k;
            bit          wr;
            logic [15:0] addr;
            logic [31:0] data;
            logic [31:0] rd;
            logic [3:0]  strb;
            int          dly;
            k    = (n % 4 == 3) ? 1 : 0;
            wr   = 1'($urandom_range(0, 1));
            addr = 16'($urandom);
            data = $urandom;
            rd   = $urandom;
            strb = 4'($urandom);
            dly  = $urandom_range(0, 20);
            do_xfer(k, wr, addr, data, strb, dly, rd, "random");
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
            paddr[k] = '0; pwdata[k] = '0; pstrb[k] = '0;
            lb_wready[k] = 1'b0; lb_rdata[k] = '0; lb_rvalid[k] = 1'b0;
        end
        test_reset();
        test_simple_write();
        test_strobed_write();
        test_write_wait();
        test_reads();
        test_timeout();
        test_no_timeout();
        test_reset_mid_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
